mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 20, data-memory word address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data word width.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports req0 / req1, input, 1 each, access request from MEM stage of core 0 / core 1.
REQ-006 The block SHALL have ports we0 / we1, input, 1 each, 1 = write (GP store), 0 = read (CP load).
REQ-007 The block SHALL have ports addr0 / addr1, input, ADDR_W each, word address.
REQ-008 The block SHALL have ports wdata0 / wdata1, input, DATA_W each, write data.
REQ-009 The block SHALL have ports gnt0 / gnt1, output, 1 each, one-cycle pulse in the cycle the access is issued to memory.
REQ-010 The block SHALL have ports rvalid0 / rvalid1, output, 1 each, one-cycle pulse when rdata holds that requester's read result.
REQ-011 The block SHALL have port rdata, output, DATA_W, registered read data shared by both requesters.
REQ-012 The block SHALL have ports mem_en, mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W), all driven to single-port synchronous memory.
REQ-013 The block SHALL have port mem_rdata, input, DATA_W, memory read data, valid the cycle after a read is issued.
REQ-014 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT; every output SHALL be registered.
REQ-016 In IDLE with no req, the FSM SHALL stay IDLE and hold mem_en = 0.
REQ-017 In IDLE with any req, the block SHALL select a winner, capture its we/addr/wdata into internal registers, and go to ISSUE.
REQ-018 When only one req is high, that requester SHALL win; when both are high, the requester named by pointer prio SHALL win.
REQ-019 After every grant, prio SHALL be set to the non-winning requester (round-robin); prio resets to 0.
REQ-020 In ISSUE, the block SHALL drive mem_en = 1, mem_we = captured we, mem_addr/mem_wdata = captured values, and the winner's gnt = 1, for exactly one cycle.
REQ-021 From ISSUE, the FSM SHALL go to IDLE on a write and to WAIT on a read.
REQ-022 In WAIT, mem_en SHALL be 0, rdata SHALL load mem_rdata at the cycle's end, and the winner's rvalid SHALL pulse in the following cycle; the FSM SHALL return to IDLE.
REQ-023 rdata SHALL hold its value until the next read completes; writes SHALL NOT change rdata.
REQ-024 req/we/addr/wdata SHALL be ignored outside IDLE; a requester SHALL hold them stable until it sees gnt and drop req the cycle after gnt unless a new access is wanted.
REQ-025 Latency SHALL be: req seen in IDLE at cycle N -> gnt and memory access at N+1 -> rvalid at N+3 (reads); back-to-back accesses SHALL be able to start at N+2 (write) or N+3 (read, IDLE overlapping rvalid).
REQ-026 gnt0 and gnt1 SHALL never be high together, nor rvalid0 and rvalid1; at most one memory access SHALL be outstanding.
REQ-027 With both reqs held continuously, grants SHALL strictly alternate 0,1,0,1...

Reset
REQ-028 While rst is high at a clock edge, the block SHALL go to IDLE, set prio = 0, gnt0/1 = 0, rvalid0/1 = 0, mem_en = mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, busy = 0.
REQ-029 Reset during ISSUE or WAIT SHALL abort the access: no rvalid SHALL follow, and no further mem_en SHALL be issued for it.

Verification
REQ-030 Single write: req0=1, we0=1, addr0=0x00010, wdata0=0xDEADBEEF -> next cycle gnt0=1, mem_en=1, mem_we=1, mem_addr=0x00010; busy low two cycles after req.
REQ-031 Single read: preload mem[0x00020]=0x12345678, req1=1, we1=0 -> gnt1 at N+1, rvalid1 at N+3 with rdata=0x12345678, rvalid0 stays 0.
REQ-032 Contention after reset: req0=req1=1 held (reads) -> first gnt0, then gnt1, then gnt0; never both together.
REQ-033 Fairness: req1 alone wins once, then req0 and req1 simultaneous -> gnt0 wins (prio moved to 0).
REQ-034 Reset mid-read: assert rst during WAIT -> rvalid0/1 remain 0, rdata=0, state IDLE, busy=0 next cycle.
REQ-035 Write then read same address: write 0x000000AA to 0x00005 via core 0, then read 0x00005 via core 1 -> rvalid1 with rdata=0x000000AA; rdata unchanged by the write.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Two-core data-memory port bundle.
// Requester side : req0/1, we0/1, addr0/1, wdata0/1 in; gnt0/1, rvalid0/1, rdata out.
// Memory side    : mem_en, mem_we, mem_addr, mem_wdata out; mem_rdata in.
// Status         : busy out (access in flight).
// slave modport is the arbiter's view; master is the cores-plus-memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory
// between the MEM stages of two cores. All outputs are registered.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave: request/grant/read-return for both
//          cores, memory command/data, busy status
//
// state | meaning
// IDLE  | no access in flight; arbitrate and capture the winner's request
// ISSUE | memory command on the bus for one cycle, winner's gnt high
// WAIT  | read data arriving from memory; load rdata, rvalid next cycle
module mem_port_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              win_q, win_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              pick1;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    win_d       = win_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // core 1 wins when it is the only requester or holds priority
    pick1       = bus.req1 & (~bus.req0 | prio_q);

    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          win_d       = pick1;
          prio_d      = ~pick1;
          gnt0_d      = ~pick1;
          gnt1_d      = pick1;
          mem_en_d    = 1'b1;
          mem_we_d    = pick1 ? bus.we1 : bus.we0;
          mem_addr_d  = pick1 ? bus.addr1 : bus.addr0;
          mem_wdata_d = pick1 ? bus.wdata1 : bus.wdata0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // mem_we_q still holds the captured direction during ISSUE
        state_d = mem_we_q ? IDLE : WAIT;
      end
      WAIT: begin
        rdata_d   = bus.mem_rdata;
        rvalid0_d = ~win_q;
        rvalid1_d = win_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      win_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      win_q       <= win_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule
